// File: rtl/lsu_arbiter.sv
// Two-port arbiter sharing one UART load/store unit between fetch and data.
// Ports: fetch_*/data_* requesters, lsu_* to the LSU, busy/grant_id status.
// Optional macro LSU_ARB_RR_EN selects round-robin; default is data priority.
module lsu_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic [1:0]        lsu_en,
  output logic [ADDR_W-1:0] lsu_addr,
  output logic [DATA_W-1:0] lsu_wdata,
  input  logic [DATA_W-1:0] lsu_rdata,
  input  logic              lsu_done,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [1:0] EN_IDLE  = 2'b00;
  localparam logic [1:0] EN_LOAD  = 2'b01;
  localparam logic [1:0] EN_STORE = 2'b10;

  logic [1:0] state;
  logic       pick_data;
  logic       any_req;

  assign any_req = fetch_req | data_req;

`ifdef LSU_ARB_RR_EN
  // rr=1 means data has the tie-break next.
  logic rr;

  assign pick_data = data_req & (~fetch_req | rr);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr <= 1'b0;
    end else if (state == IDLE && any_req) begin
      rr <= ~pick_data;
    end
  end
`else
  assign pick_data = data_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      lsu_en      <= EN_IDLE;
      lsu_addr    <= '0;
      lsu_wdata   <= '0;
      fetch_ack   <= 1'b0;
      data_ack    <= 1'b0;
      fetch_rdata <= '0;
      data_rdata  <= '0;
      busy        <= 1'b0;
      grant_id    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          fetch_ack <= 1'b0;
          data_ack  <= 1'b0;
          if (any_req) begin
            state    <= GRANT;
            busy     <= 1'b1;
            grant_id <= pick_data;
            if (pick_data) begin
              lsu_en    <= data_we ? EN_STORE : EN_LOAD;
              lsu_addr  <= data_addr;
              lsu_wdata <= data_wdata;
            end else begin
              lsu_en    <= EN_LOAD;
              lsu_addr  <= fetch_addr;
              lsu_wdata <= '0;
            end
          end
        end
        GRANT: begin
          // Dropping en_ls with done keeps the LSU from re-arming.
          if (lsu_done) begin
            lsu_en <= EN_IDLE;
            state  <= RESP;
            if (grant_id) begin
              data_ack <= 1'b1;
              if (lsu_en == EN_LOAD) begin
                data_rdata <= lsu_rdata;
              end
            end else begin
              fetch_ack   <= 1'b1;
              fetch_rdata <= lsu_rdata;
            end
          end
        end
        RESP: begin
          fetch_ack <= 1'b0;
          data_ack  <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: fetch, store, arbitration,
// en_ls gap after done, stray done, mid-grant reset.
module tb_lsu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_ack;
  logic [15:0] fetch_rdata;
  logic        data_req;
  logic        data_we;
  logic [7:0]  data_addr;
  logic [15:0] data_wdata;
  logic        data_ack;
  logic [15:0] data_rdata;
  logic [1:0]  lsu_en;
  logic [7:0]  lsu_addr;
  logic [15:0] lsu_wdata;
  logic [15:0] lsu_rdata;
  logic        lsu_done;
  logic        busy;
  logic        grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_rdata(data_rdata),
    .lsu_en(lsu_en), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_rdata(lsu_rdata),
    .lsu_done(lsu_done), .busy(busy), .grant_id(grant_id)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0;
    data_addr = '0; data_wdata = '0;
    lsu_rdata = '0; lsu_done = 1'b0;
    step(); step();
    checks++;
    if (lsu_en !== 2'b00 || busy !== 1'b0 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl en=%b busy=%b gid=%b exp 00 0 0",
               lsu_en, busy, grant_id);
    end
    checks++;
    if (fetch_ack !== 1'b0 || data_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack got %b%b exp 00", fetch_ack, data_ack);
    end
    checks++;
    if (lsu_addr !== 8'h00 || lsu_wdata !== 16'h0000 ||
        fetch_rdata !== 16'h0000 || data_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h exp zeros",
               lsu_addr, lsu_wdata, fetch_rdata, data_rdata);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    fetch_req = 1'b1; fetch_addr = 8'h12;
    step();
    checks++;
    if (lsu_en !== 2'b01 || lsu_addr !== 8'h12 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_grant en=%b addr=%h busy=%b exp 01 12 1",
               lsu_en, lsu_addr, busy);
    end
    checks++;
    if (grant_id !== 1'b0 || lsu_wdata !== 16'h0000) begin
      errors++;
      $display("FAIL fetch_gid gid=%b wdata=%h exp 0 0000",
               grant_id, lsu_wdata);
    end
    fetch_addr = 8'h34;
    step();
    checks++;
    if (lsu_addr !== 8'h12 || lsu_en !== 2'b01 || fetch_ack !== 1'b0) begin
      errors++;
      $display("FAIL fetch_hold addr=%h en=%b ack=%b exp 12 01 0",
               lsu_addr, lsu_en, fetch_ack);
    end
    lsu_rdata = 16'hBEEF; lsu_done = 1'b1;
    step();
    lsu_done = 1'b0; lsu_rdata = 16'h0000;
    checks++;
    if (fetch_ack !== 1'b1 || data_ack !== 1'b0 || lsu_en !== 2'b00) begin
      errors++;
      $display("FAIL fetch_resp ack=%b%b en=%b exp 10 00",
               fetch_ack, data_ack, lsu_en);
    end
    checks++;
    if (fetch_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL fetch_rdata got %h exp beef", fetch_rdata);
    end
    fetch_req = 1'b0;
    step();
    checks++;
    if (fetch_ack !== 1'b0 || lsu_en !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_idle ack=%b en=%b busy=%b exp 0 00 0",
               fetch_ack, lsu_en, busy);
    end
    step();
    checks++;
    if (lsu_en !== 2'b00 || fetch_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL fetch_gap en=%b rdata=%h exp 00 beef",
               lsu_en, fetch_rdata);
    end
  endtask

  task automatic test_store();
    data_req = 1'b1; data_we = 1'b1;
    data_addr = 8'h40; data_wdata = 16'hA55A;
    step();
    data_wdata = 16'h0000;
    checks++;
    if (lsu_en !== 2'b10 || lsu_addr !== 8'h40 ||
        lsu_wdata !== 16'hA55A || grant_id !== 1'b1) begin
      errors++;
      $display("FAIL store_grant en=%b a=%h wd=%h gid=%b exp 10 40 a55a 1",
               lsu_en, lsu_addr, lsu_wdata, grant_id);
    end
    lsu_rdata = 16'h1234; lsu_done = 1'b1;
    step();
    lsu_done = 1'b0;
    checks++;
    if (data_ack !== 1'b1 || fetch_ack !== 1'b0 || lsu_en !== 2'b00) begin
      errors++;
      $display("FAIL store_resp ack=%b%b en=%b exp 01 00",
               fetch_ack, data_ack, lsu_en);
    end
    checks++;
    if (data_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL store_rdata got %h exp 0000", data_rdata);
    end
    data_req = 1'b0; data_we = 1'b0;
    step();
    checks++;
    if (data_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL store_idle ack=%b busy=%b exp 0 0", data_ack, busy);
    end
  endtask

  task automatic test_stray_done();
    lsu_done = 1'b1; lsu_rdata = 16'hDEAD;
    step();
    lsu_done = 1'b0;
    step();
    checks++;
    if (fetch_ack !== 1'b0 || data_ack !== 1'b0 ||
        busy !== 1'b0 || lsu_en !== 2'b00) begin
      errors++;
      $display("FAIL stray_done ack=%b%b busy=%b en=%b exp 00 0 00",
               fetch_ack, data_ack, busy, lsu_en);
    end
    checks++;
    if (fetch_rdata !== 16'hBEEF || data_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL stray_rdata got %h %h exp beef 0000",
               fetch_rdata, data_rdata);
    end
  endtask

  task automatic test_arbitration();
    logic exp_win [4];
    logic [15:0] val;
`ifdef LSU_ARB_RR_EN
    exp_win[0] = 1'b0; exp_win[1] = 1'b1; exp_win[2] = 1'b0;
`else
    exp_win[0] = 1'b1; exp_win[1] = 1'b1; exp_win[2] = 1'b1;
`endif
    exp_win[3] = 1'b0;
    fetch_req = 1'b1; fetch_addr = 8'h12;
    data_we = 1'b0; data_addr = 8'h50;
    for (int i = 0; i < 4; i++) begin
      data_req = (i < 3);
      val = 16'h1000 + 16'(i);
      step();
      checks++;
      if (grant_id !== exp_win[i] || lsu_en !== 2'b01 ||
          lsu_addr !== (exp_win[i] ? 8'h50 : 8'h12)) begin
        errors++;
        $display("FAIL arb_grant%0d gid=%b en=%b a=%h exp gid %b",
                 i, grant_id, lsu_en, lsu_addr, exp_win[i]);
      end
      lsu_rdata = val; lsu_done = 1'b1;
      step();
      lsu_done = 1'b0;
      checks++;
      if (fetch_ack !== ~exp_win[i] || data_ack !== exp_win[i] ||
          lsu_en !== 2'b00) begin
        errors++;
        $display("FAIL arb_ack%0d ack=%b%b en=%b exp win %b",
                 i, fetch_ack, data_ack, lsu_en, exp_win[i]);
      end
      checks++;
      if ((exp_win[i] ? data_rdata : fetch_rdata) !== val) begin
        errors++;
        $display("FAIL arb_rdata%0d got %h %h exp %h",
                 i, fetch_rdata, data_rdata, val);
      end
      step();
      checks++;
      if (lsu_en !== 2'b00 || busy !== 1'b0 ||
          fetch_ack !== 1'b0 || data_ack !== 1'b0) begin
        errors++;
        $display("FAIL arb_gap%0d en=%b busy=%b ack=%b%b exp 00 0 00",
                 i, lsu_en, busy, fetch_ack, data_ack);
      end
    end
    fetch_req = 1'b0; data_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    fetch_req = 1'b1; fetch_addr = 8'h77;
    step();
    checks++;
    if (busy !== 1'b1 || lsu_en !== 2'b01) begin
      errors++;
      $display("FAIL mid_grant busy=%b en=%b exp 1 01", busy, lsu_en);
    end
    reset = 1'b0; fetch_req = 1'b0;
    lsu_done = 1'b1; lsu_rdata = 16'h5555;
    step();
    lsu_done = 1'b0;
    checks++;
    if (lsu_en !== 2'b00 || busy !== 1'b0 || lsu_addr !== 8'h00 ||
        fetch_rdata !== 16'h0000 || data_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset en=%b busy=%b a=%h rd=%h %h exp zeros",
               lsu_en, busy, lsu_addr, fetch_rdata, data_rdata);
    end
    reset = 1'b1;
    step();
    checks++;
    if (fetch_ack !== 1'b0 || data_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_noack ack=%b%b busy=%b exp 00 0",
               fetch_ack, data_ack, busy);
    end
    data_req = 1'b1; data_we = 1'b0; data_addr = 8'h66;
    step();
    checks++;
    if (grant_id !== 1'b1 || lsu_en !== 2'b01 || lsu_addr !== 8'h66) begin
      errors++;
      $display("FAIL post_grant gid=%b en=%b a=%h exp 1 01 66",
               grant_id, lsu_en, lsu_addr);
    end
    lsu_rdata = 16'hCAFE; lsu_done = 1'b1;
    step();
    lsu_done = 1'b0; data_req = 1'b0;
    checks++;
    if (data_ack !== 1'b1 || data_rdata !== 16'hCAFE) begin
      errors++;
      $display("FAIL post_done ack=%b rd=%h exp 1 cafe",
               data_ack, data_rdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_stray_done();
    test_arbitration();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
